fp_round_pack: RTL and testbench
================================

// Module: fp_round_pack
// PURPOSE
//  Rounding and packing stage, directly downstream of the exponent/significand priority encoder.
//  - Consumes one {sign, exp, sig, fifth} token per handshake.
//  - Rounds the significand half-up using the fifth bit, then renormalises or saturates.
//  - Emits the packed 8-bit float {S, E[2:0], F[3:0]} through a 2-deep valid/ready pipeline.
//  - Keeps saturating statistics counters for round-ups and overflow clamps.
// PARAMETERS
//  CNT_W   8   width of round_cnt and sat_cnt; counters stick at all-ones.
// PORTS
//  clk        in   1      system clock; all state updates on the rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      upstream token present
//  in_ready   out  1      stage can accept a token this cycle
//  in_sign    in   1      sign of the value (1 = negative)
//  in_exp     in   3      exponent from the priority encoder, 0..7
//  in_sig     in   4      truncated significand
//  in_fifth   in   1      first bit dropped below in_sig (the rounding bit)
//  out_valid  out  1      fp_out holds a valid packed float
//  out_ready  in   1      downstream accepts fp_out this cycle
//  fp_out     out  8      {sign, exp[2:0], sig[3:0]}
//  clr_stats  in   1      synchronous clear of both counters
//  round_cnt  out  CNT_W  count of accepted tokens with in_fifth = 1
//  sat_cnt    out  CNT_W  count of accepted tokens that clamped to max magnitude
// BEHAVIOUR
//  Reset (rst = 1 at a clock edge):
//   - s1_valid, out_valid, fp_out, round_cnt and sat_cnt all go to 0.
//   - in_ready is 0 while rst is high and 1 on the first cycle after.
//   - Any tokens in flight are discarded, with no partial output.
//  Handshake:
//   - Transfer happens when valid && ready. Valid must not depend on ready.
//   - While out_valid = 1 && out_ready = 0, fp_out holds stable.
//  Pipeline:
//   - S1 register stores the rounded result; S2 is the output register.
//   - adv2 = !out_valid || out_ready
//   - adv1 = s1_valid && adv2
//   - in_ready = !s1_valid || adv2 (combinational; a full pipe accepts while draining).
//   - Latency 2 clocks from accept to out_valid when out_ready = 1; throughput 1 token per clock.
//   - Token order is always preserved; no token is dropped or duplicated under backpressure.
//  Rounding (computed on in_* before the S1 register):
//   - fifth = 0: E = exp, F = sig.
//   - fifth = 1 and sig != 4'b1111: F = sig + 1, E = exp.
//   - fifth = 1, sig = 4'b1111, exp != 7: F = 4'b1000, E = exp + 1 (renormalise).
//   - fifth = 1, sig = 4'b1111, exp = 7: F = 4'b1111, E = 3'b111; raises the sat event.
//   - The sign passes through unchanged, including for zero magnitude.
//  Counters (update only on an input transfer, in_valid && in_ready):
//   - round_cnt increments when in_fifth = 1.
//   - sat_cnt increments on the sat event.
//   - Both hold at 2^CNT_W - 1 and never wrap.
//   - clr_stats wins over a same-cycle increment: the result is 0, not 1.
// STRUCTURE
//  - Shared package fp8_pkg holds EXP_W = 3, SIG_W = 4, EXP_MAX = 3'd7, SIG_MAX = 4'hF,
//    SIG_RENORM = 4'h8, and the packed-float field offsets.
//  - One combinational sub-module, fp_round_core, takes {exp, sig, fifth} and returns {exp, sig, sat}.
//  - The top level holds the two pipeline registers, the handshake logic and the counters.
// TESTING
//  1. exp=3, sig=1011, fifth=1, sign=0, out_ready=1 -> fp_out=8'b0_011_1100 two clocks later; round_cnt=1.
//  2. exp=3, sig=1111, fifth=1 -> fp_out=8'b0_100_1000.
//     exp=5, sig=1010, fifth=0 -> fp_out=8'b0_101_1010; sat_cnt stays 0.
//  3. sign=1, exp=7, sig=1111, fifth=1 -> fp_out=8'b1_111_1111; sat_cnt=1.
//  4. Backpressure: hold out_ready=0 and offer tokens A, B, C back-to-back.
//     -> A and B accepted; in_ready=0 while C waits; fp_out=A held stable.
//     -> Raise out_ready: A, B, C emitted in order on consecutive clocks.
//  5. Reset with 2 tokens in flight -> next clock out_valid=0 and both counters=0.
//     -> A token sent after reset emerges correctly with 2-clock latency.
//  6. Send 300 tokens with fifth=1 and CNT_W=8 -> round_cnt=255.
//     clr_stats in the same cycle as an accepted fifth=1 token -> round_cnt=0.

Source files
------------

// File: rtl/fp8_pkg.sv
// Shared 8-bit float format: field widths, limits, bit offsets and the payload structs
// exchanged between the rounding core and the pack stage.
package fp8_pkg;

  localparam int unsigned EXP_W = 3;
  localparam int unsigned SIG_W = 4;
  localparam int unsigned FP_W  = 1 + EXP_W + SIG_W;

  localparam logic [EXP_W-1:0] EXP_MAX    = 3'd7;
  localparam logic [SIG_W-1:0] SIG_MAX    = 4'hF;
  localparam logic [SIG_W-1:0] SIG_RENORM = 4'h8;

  localparam int unsigned FP_SIG_LSB  = 0;
  localparam int unsigned FP_EXP_LSB  = SIG_W;
  localparam int unsigned FP_SIGN_BIT = EXP_W + SIG_W;

  typedef struct packed {
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
    logic             fifth;
  } round_in_t;

  typedef struct packed {
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
    logic             sat;
  } round_out_t;

  // Place sign, exponent and significand at their packed-float offsets.
  function automatic logic [FP_W-1:0] fp_pack(input logic             sign,
                                              input logic [EXP_W-1:0] exp,
                                              input logic [SIG_W-1:0] sig);
    logic [FP_W-1:0] r;
    r                         = '0;
    r[FP_SIGN_BIT]            = sign;
    r[FP_EXP_LSB +: EXP_W]    = exp;
    r[FP_SIG_LSB +: SIG_W]    = sig;
    return r;
  endfunction

endpackage

// File: rtl/fp_round_core.sv
// Half-up rounding of a truncated significand using the first dropped bit,
// with renormalisation on significand carry-out and clamping at the top exponent.
module fp_round_core
  import fp8_pkg::*;
(
  input  round_in_t  din,
  output round_out_t dout_c
);

  always_comb begin
    dout_c.exp = din.exp;
    dout_c.sig = din.sig;
    dout_c.sat = 1'b0;
    if (din.fifth) begin
      if (din.sig != SIG_MAX) begin
        dout_c.sig = din.sig + SIG_W'(1);
      end else if (din.exp != EXP_MAX) begin
        // Carry out of the significand: shift back to 1.000 and bump the exponent.
        dout_c.sig = SIG_RENORM;
        dout_c.exp = din.exp + EXP_W'(1);
      end else begin
        dout_c.sig = SIG_MAX;
        dout_c.exp = EXP_MAX;
        dout_c.sat = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_round_pack.sv
// Rounding and packing stage: two-register valid/ready pipeline emitting packed 8-bit
// floats, plus saturating round-up and overflow-clamp statistics counters.
module fp_round_pack
  import fp8_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [SIG_W-1:0] in_sig,
  input  logic             in_fifth,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  fp_out,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] round_cnt,
  output logic [CNT_W-1:0] sat_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic            s1_valid;
  logic [FP_W-1:0] s1_fp;
  logic            adv1;
  logic            adv2;
  logic            accept;
  round_in_t       rin;
  round_out_t      rout;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = s1_valid && adv2;
  assign in_ready = !rst && (!s1_valid || adv2);
  assign accept   = in_valid && in_ready;

  assign rin.exp   = in_exp;
  assign rin.sig   = in_sig;
  assign rin.fifth = in_fifth;

  fp_round_core u_core (
    .din    (rin),
    .dout_c (rout)
  );

  // S1 holds the rounded token; S2 (fp_out) only moves when downstream can take it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_fp     <= '0;
      out_valid <= 1'b0;
      fp_out    <= '0;
    end else begin
      if (adv2) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          fp_out <= s1_fp;
        end
      end
      if (accept) begin
        s1_valid <= 1'b1;
        s1_fp    <= fp_pack(in_sign, rout.exp, rout.sig);
      end else if (adv1) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Statistics stick at all-ones; a clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      round_cnt <= '0;
      sat_cnt   <= '0;
    end else begin
      if (accept && in_fifth && (round_cnt != CNT_MAX)) begin
        round_cnt <= round_cnt + CNT_W'(1);
      end
      if (accept && rout.sat && (sat_cnt != CNT_MAX)) begin
        sat_cnt <= sat_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fp_round_pack.sv
// Randomized and directed bench for fp_round_pack, checked against an arithmetic
// rounding model and a token queue standing in for the two-deep pipeline.
module tb_fp_round_pack;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_sign = 1'b0;
  logic [2:0] in_exp = 3'd0;
  logic [3:0] in_sig = 4'd0;
  logic       in_fifth = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] fp_out;
  logic       clr_stats = 1'b0;
  logic [7:0] round_cnt;
  logic [7:0] sat_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q[$];
  int         m_round = 0;
  int         m_sat = 0;
  bit         seen_rst = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_fp = 8'h00;

  fp_round_pack #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_sig    (in_sig),
    .in_fifth  (in_fifth),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fp_out    (fp_out),
    .clr_stats (clr_stats),
    .round_cnt (round_cnt),
    .sat_cnt   (sat_cnt)
  );

  always #5 clk = ~clk;

  // Value-level rounding: add the dropped bit, renormalise a 16 back to 8, clamp past exp 7.
  function automatic logic [8:0] model_round(input logic s, input int e, input int g, input logic f);
    int m;
    int ee;
    logic sat;
    m   = g + int'(f);
    ee  = e;
    sat = 1'b0;
    if (m == 16) begin
      m  = 8;
      ee = e + 1;
    end
    if (ee > 7) begin
      ee  = 7;
      m   = 15;
      sat = 1'b1;
    end
    return {sat, s, 3'(ee), 4'(m)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: capacity-2 queue predicts in_ready, output order and counter values.
  always @(negedge clk) begin
    logic [8:0] m;
    logic       exp_rdy;
    if (seen_rst) begin
      exp_rdy = !rst && !(q.size() == 2 && !out_ready);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (q.size() == 0) chk("out_valid_idle", 32'(out_valid), 32'(0));
      if (prev_stall) chk("stall_hold", 32'({out_valid, fp_out}), 32'({1'b1, prev_fp}));
      chk("round_cnt", 32'(round_cnt), 32'(m_round));
      chk("sat_cnt", 32'(sat_cnt), 32'(m_sat));
    end
    prev_stall = seen_rst && !rst && out_valid && !out_ready;
    prev_fp    = fp_out;
    if (rst) begin
      q.delete();
      m_round  = 0;
      m_sat    = 0;
      seen_rst = 1'b1;
    end else if (seen_rst) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL pop_empty: got fp_out %0h expected no token at %0t", fp_out, $time);
        end else begin
          chk("fp_out", 32'(fp_out), 32'(q.pop_front()));
        end
      end
      m = model_round(in_sign, int'(in_exp), int'(in_sig), in_fifth);
      if (in_valid && in_ready) q.push_back(m[7:0]);
      if (clr_stats) begin
        m_round = 0;
        m_sat   = 0;
      end else if (in_valid && in_ready) begin
        if (in_fifth && m_round < 255) m_round++;
        if (m[8] && m_sat < 255) m_sat++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic s, input logic [2:0] e, input logic [3:0] g, input logic f);
    bit done;
    done = 1'b0;
    tick();
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_sig   = g;
    in_fifth = f;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
    end
    if (done) begin
      tick();
    end else begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 within 100 cycles");
    end
    in_valid = 1'b0;
  endtask

  // Expects the just-sent token to appear exactly two edges after acceptance.
  task automatic expect_out(input string nm, input logic [7:0] v);
    @(negedge clk);
    chk({nm, "_early"}, 32'(out_valid), 32'(0));
    @(negedge clk);
    chk({nm, "_valid"}, 32'(out_valid), 32'(1));
    chk(nm, 32'(fp_out), 32'(v));
  endtask

  initial begin
    bit took;
    repeat (3) tick();
    rst = 1'b0;
    out_ready = 1'b1;

    send(1'b0, 3'd3, 4'b1011, 1'b1);
    expect_out("t1_fp", 8'b0_011_1100);
    chk("t1_round_cnt", 32'(round_cnt), 32'(1));

    send(1'b0, 3'd3, 4'b1111, 1'b1);
    expect_out("t2_renorm", 8'b0_100_1000);
    send(1'b0, 3'd5, 4'b1010, 1'b0);
    expect_out("t2_nofifth", 8'b0_101_1010);
    chk("t2_sat_cnt", 32'(sat_cnt), 32'(0));

    send(1'b1, 3'd7, 4'b1111, 1'b1);
    expect_out("t3_sat", 8'b1_111_1111);
    chk("t3_sat_cnt", 32'(sat_cnt), 32'(1));
    chk("t3_round_cnt", 32'(round_cnt), 32'(3));

    // Backpressure: A, B fill the pipe, C waits.
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 3'd2; in_sig = 4'b0101; in_fifth = 1'b0;
    @(negedge clk);
    chk("t4_rdy_a", 32'(in_ready), 32'(1));
    tick();
    in_sign = 1'b1; in_exp = 3'd4; in_sig = 4'b0011; in_fifth = 1'b1;
    @(negedge clk);
    chk("t4_rdy_b", 32'(in_ready), 32'(1));
    tick();
    in_sign = 1'b0; in_exp = 3'd6; in_sig = 4'b1111; in_fifth = 1'b1;
    @(negedge clk);
    chk("t4_rdy_c_blocked", 32'(in_ready), 32'(0));
    chk("t4_hold_a", 32'({out_valid, fp_out}), 32'({1'b1, 8'b0_010_0101}));
    tick();
    tick();
    @(negedge clk);
    chk("t4_hold_a_late", 32'({in_ready, out_valid, fp_out}), 32'({2'b01, 8'b0_010_0101}));
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_out_a", 32'({in_ready, out_valid, fp_out}), 32'({2'b11, 8'b0_010_0101}));
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4_out_b", 32'({out_valid, fp_out}), 32'({1'b1, 8'b1_100_0100}));
    @(negedge clk);
    chk("t4_out_c", 32'({out_valid, fp_out}), 32'({1'b1, 8'b0_111_1000}));
    @(negedge clk);
    chk("t4_drained", 32'(out_valid), 32'(0));

    // Reset with two tokens in flight.
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 3'd1; in_sig = 4'b0001; in_fifth = 1'b1;
    @(negedge clk);
    tick();
    in_exp = 3'd7; in_sig = 4'b1111; in_fifth = 1'b1;
    @(negedge clk);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rdy_in_rst", 32'(in_ready), 32'(0));
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_after_rst", 32'({in_ready, out_valid, round_cnt, sat_cnt}), 32'({2'b10, 16'h0000}));
    out_ready = 1'b1;
    send(1'b1, 3'd0, 4'b0000, 1'b0);
    expect_out("t5_post_rst", 8'b1_000_0000);

    // Counter saturation and clear priority.
    tick();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    for (int i = 0; i < 300; i++) send(1'($urandom), 3'($urandom), 4'($urandom), 1'b1);
    @(negedge clk);
    chk("t6_round_sat", 32'(round_cnt), 32'(255));
    tick();
    clr_stats = 1'b1;
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 3'd2; in_sig = 4'b0110; in_fifth = 1'b1;
    @(negedge clk);
    chk("t6_clr_accept", 32'(in_ready), 32'(1));
    tick();
    clr_stats = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_clr_wins", 32'(round_cnt), 32'(0));

    // Random traffic; a pending token is held until accepted.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      took = in_valid && in_ready;
      tick();
      if (!in_valid || took) begin
        in_valid = ($urandom % 4) != 0;
        in_sign  = 1'($urandom);
        in_exp   = ($urandom % 3 == 0) ? 3'd7 : 3'($urandom);
        in_sig   = ($urandom % 3 == 0) ? 4'hF : 4'($urandom);
        in_fifth = 1'($urandom);
      end
      out_ready = ($urandom % 3) != 0;
      clr_stats = ($urandom % 64) == 0;
    end
    tick();
    in_valid  = 1'b0;
    clr_stats = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain_empty", 32'(q.size()), 32'(0));
    chk("drain_idle", 32'(out_valid), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule
